// File: rtl/des_key_schedule_ctrl.sv
// DES key schedule sequencer: PC-1 load, per-step C/D rotation and PC-2.
// Streams the 16 round subkeys over a valid/ready handshake.
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   start, key_in       load a 64-bit key (DES bit 1 = key_in[63]) in IDLE
//   decrypt             0: K1..K16, 1: K16..K1 (sampled with start)
//   abort               drop the current schedule, back to IDLE
//   ready               1 in IDLE
//   subkey_valid/ready  subkey handshake; subkey[47] = PC-2 bit 1
//   round               emission index 0..15 of the current subkey
//   done                1-cycle pulse after the 16th subkey is taken
//   key_parity_err      sticky even-parity flag (PARITY_CHECK=1 only)
module des_key_schedule_ctrl #(
  parameter int PARITY_CHECK = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] key_in,
  input  logic        decrypt,
  input  logic        abort,
  output logic        ready,
  output logic        subkey_valid,
  input  logic        subkey_ready,
  output logic [47:0] subkey,
  output logic [3:0]  round,
  output logic        done,
  output logic        key_parity_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // key_in bit index feeding each PC-1 output bit (C bit 1 first)
  localparam logic [5:0] PC1_IDX [56] = '{
    6'd7,  6'd15, 6'd23, 6'd31, 6'd39, 6'd47, 6'd55,
    6'd63, 6'd6,  6'd14, 6'd22, 6'd30, 6'd38, 6'd46,
    6'd54, 6'd62, 6'd5,  6'd13, 6'd21, 6'd29, 6'd37,
    6'd45, 6'd53, 6'd61, 6'd4,  6'd12, 6'd20, 6'd28,
    6'd1,  6'd9,  6'd17, 6'd25, 6'd33, 6'd41, 6'd49,
    6'd57, 6'd2,  6'd10, 6'd18, 6'd26, 6'd34, 6'd42,
    6'd50, 6'd58, 6'd3,  6'd11, 6'd19, 6'd27, 6'd35,
    6'd43, 6'd51, 6'd59, 6'd36, 6'd44, 6'd52, 6'd60
  };

  // {C,D} bit index feeding each PC-2 output bit (bit 1 first)
  localparam logic [5:0] PC2_IDX [48] = '{
    6'd42, 6'd39, 6'd45, 6'd32, 6'd55, 6'd51,
    6'd53, 6'd28, 6'd41, 6'd50, 6'd35, 6'd46,
    6'd33, 6'd37, 6'd44, 6'd52, 6'd30, 6'd48,
    6'd40, 6'd49, 6'd29, 6'd36, 6'd43, 6'd54,
    6'd15, 6'd4,  6'd25, 6'd19, 6'd9,  6'd1,
    6'd26, 6'd16, 6'd5,  6'd11, 6'd23, 6'd8,
    6'd12, 6'd7,  6'd17, 6'd0,  6'd22, 6'd3,
    6'd10, 6'd14, 6'd6,  6'd20, 6'd27, 6'd24
  };

  function automatic logic [55:0] pc1(input logic [63:0] k);
    logic [55:0] r;
    r = '0;
    for (logic [5:0] i = 6'd0; i < 6'd56; i++)
      r[6'd55 - i] = k[PC1_IDX[i]];
    return r;
  endfunction

  function automatic logic [47:0] pc2(input logic [55:0] cd);
    logic [47:0] r;
    r = '0;
    for (logic [5:0] j = 6'd0; j < 6'd48; j++)
      r[6'd47 - j] = cd[PC2_IDX[j]];
    return r;
  endfunction

  function automatic logic [27:0] rot(
    input logic [27:0] x,
    input logic        left,
    input logic        two
  );
    logic [27:0] r;
    unique case (1'b1)
      left && two:   r = {x[25:0], x[27:26]};
      left && !two:  r = {x[26:0], x[27]};
      !left && two:  r = {x[1:0], x[27:2]};
      default:       r = {x[0], x[27:1]};
    endcase
    return r;
  endfunction

  state_t      state, state_nxt;
  logic [27:0] c_q, d_q;
  logic [3:0]  round_q, round_nx;
  logic        dec_q, perr_q;
  logic [55:0] pc1_cd;
  logic [7:0]  byte_odd;
  logic        one_step;
  logic        accept;

  assign pc1_cd   = pc1(key_in);
  assign round_nx = round_q + 4'd1;
  assign accept   = start && !abort;

  // Steps 1, 8 and 15 shift by one in both directions; the
  // encrypt load (step 0) is handled separately.
  assign one_step = (round_nx == 4'd1) || (round_nx == 4'd8) ||
                    (round_nx == 4'd15);

  genvar g;
  for (g = 0; g < 8; g++) begin : g_par
    assign byte_odd[g] = ^key_in[8*g +: 8];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = RUN;
      RUN: begin
        if (abort)
          state_nxt = IDLE;
        else if (subkey_ready && round_q == 4'd15)
          state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    ready        = (state == IDLE);
    subkey_valid = (state == RUN);
    done         = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      c_q     <= '0;
      d_q     <= '0;
      round_q <= '0;
      dec_q   <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          c_q     <= decrypt ? pc1_cd[55:28]
                             : rot(pc1_cd[55:28], 1'b1, 1'b0);
          d_q     <= decrypt ? pc1_cd[27:0]
                             : rot(pc1_cd[27:0], 1'b1, 1'b0);
          round_q <= '0;
          dec_q   <= decrypt;
          perr_q  <= (PARITY_CHECK != 0) && !(&byte_odd);
        end
        RUN: begin
          if (abort) begin
            round_q <= '0;
          end else if (subkey_ready && round_q != 4'd15) begin
            round_q <= round_nx;
            c_q     <= rot(c_q, !dec_q, !one_step);
            d_q     <= rot(d_q, !dec_q, !one_step);
          end
        end
        DONE:    round_q <= '0;
        default: round_q <= '0;
      endcase
    end
  end

  assign subkey         = pc2({c_q, d_q});
  assign round          = round_q;
  assign key_parity_err = perr_q;

endmodule

// File: tb/tb_des_key_schedule_ctrl.sv
// Testbench for des_key_schedule_ctrl: directed and random keys
// checked against a DES key-schedule reference model.
module tb_des_key_schedule_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [63:0] key_in;
  logic        decrypt;
  logic        abort;
  logic        ready;
  logic        subkey_valid;
  logic        subkey_ready;
  logic [47:0] subkey;
  logic [3:0]  round;
  logic        done;
  logic        key_parity_err;

  int n_tot  = 0;
  int n_pass = 0;

  logic [47:0] exp_ks [16];
  logic [47:0] got_ks [16];
  logic [47:0] t1_ks  [16];
  logic        exp_perr;

  int PC1 [56] = '{
    57, 49, 41, 33, 25, 17, 9,  1,  58, 50, 42, 34, 26, 18,
    10, 2,  59, 51, 43, 35, 27, 19, 11, 3,  60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7,  62, 54, 46, 38, 30, 22,
    14, 6,  61, 53, 45, 37, 29, 21, 13, 5,  28, 20, 12, 4
  };
  int PC2 [48] = '{
    14, 17, 11, 24, 1,  5,  3,  28, 15, 6,  21, 10,
    23, 19, 12, 4,  26, 8,  16, 7,  27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int SH [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  des_key_schedule_ctrl #(.PARITY_CHECK(1)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .key_in         (key_in),
    .decrypt        (decrypt),
    .abort          (abort),
    .ready          (ready),
    .subkey_valid   (subkey_valid),
    .subkey_ready   (subkey_ready),
    .subkey         (subkey),
    .round          (round),
    .done           (done),
    .key_parity_err (key_parity_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Textbook schedule: rotate C/D left by the shift table,
  // PC-2 each round, reverse the list for decryption.
  task automatic build_model(input logic [63:0] key, input bit dec);
    logic [27:0] c, d;
    logic [63:0] t;
    logic [55:0] cd, u;
    logic [47:0] k;
    logic [47:0] enc [16];
    c = '0;
    d = '0;
    for (int i = 0; i < 28; i++) begin
      t = key >> (64 - PC1[i]);
      c = {c[26:0], t[0]};
      t = key >> (64 - PC1[28 + i]);
      d = {d[26:0], t[0]};
    end
    for (int r = 0; r < 16; r++) begin
      c = (c << SH[r]) | (c >> (28 - SH[r]));
      d = (d << SH[r]) | (d >> (28 - SH[r]));
      cd = {c, d};
      k = '0;
      for (int j = 0; j < 48; j++) begin
        u = cd >> (56 - PC2[j]);
        k = {k[46:0], u[0]};
      end
      enc[r] = k;
    end
    for (int r = 0; r < 16; r++)
      exp_ks[r] = dec ? enc[15 - r] : enc[r];
    exp_perr = 1'b0;
    for (int b = 0; b < 8; b++)
      if ($countones((key >> (8 * b)) & 64'hFF) % 2 == 0)
        exp_perr = 1'b1;
  endtask

  task automatic run_key(input logic [63:0] key, input bit dec,
                         input bit rnd, input bit poke,
                         input int cut_at, input bit cut_rst);
    logic [47:0] last_k;
    logic [3:0]  last_r;
    bit          stall, rdy;
    int          hs, cyc;
    build_model(key, dec);
    @(negedge clk);
    chk("ready_before_start", 64'(ready), 64'd1);
    start   = 1'b1;
    key_in  = key;
    decrypt = dec;
    @(negedge clk);
    start   = 1'b0;
    key_in  = {$urandom, $urandom};
    decrypt = ~dec;
    chk("parity_err", 64'(key_parity_err), 64'(exp_perr));
    hs     = 0;
    cyc    = 0;
    stall  = 1'b0;
    last_k = '0;
    last_r = '0;
    while (hs < 16 && cyc < 300) begin
      start = 1'b0;
      chk("valid_in_run", 64'(subkey_valid), 64'd1);
      if (stall) begin
        chk("stall_subkey", 64'(subkey), 64'(last_k));
        chk("stall_round", 64'(round), 64'(last_r));
      end
      if (hs == cut_at) begin
        if (cut_rst) reset = 1'b1;
        else         abort = 1'b1;
        subkey_ready = 1'b1;
        @(negedge clk);
        reset        = 1'b0;
        abort        = 1'b0;
        subkey_ready = 1'b0;
        chk("cut_valid", 64'(subkey_valid), 64'd0);
        chk("cut_ready", 64'(ready), 64'd1);
        chk("cut_done", 64'(done), 64'd0);
        if (cut_rst) begin
          chk("rst_round", 64'(round), 64'd0);
          chk("rst_subkey", 64'(subkey), 64'd0);
          chk("rst_perr", 64'(key_parity_err), 64'd0);
        end
        @(negedge clk);
        chk("cut_done_later", 64'(done), 64'd0);
        chk("cut_valid_later", 64'(subkey_valid), 64'd0);
        return;
      end
      rdy = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      subkey_ready = rdy;
      if (rdy) begin
        chk("round_idx", 64'(round), 64'(hs));
        chk("subkey", 64'(subkey), 64'(exp_ks[hs]));
        got_ks[hs] = subkey;
        hs++;
      end
      stall  = !rdy;
      last_k = subkey;
      last_r = round;
      if (poke && rdy && hs == 5) begin
        start  = 1'b1;
        key_in = ~key;
      end
      @(negedge clk);
      cyc++;
    end
    subkey_ready = 1'b0;
    start        = 1'b0;
    chk("handshakes", 64'(hs), 64'd16);
    chk("done_pulse", 64'(done), 64'd1);
    chk("done_valid", 64'(subkey_valid), 64'd0);
    chk("done_ready", 64'(ready), 64'd0);
    chk("perr_sticky", 64'(key_parity_err), 64'(exp_perr));
    if (!rnd) chk("valid_cycles", 64'(cyc), 64'd16);
    @(negedge clk);
    chk("after_done", 64'(done), 64'd0);
    chk("after_ready", 64'(ready), 64'd1);
    chk("after_valid", 64'(subkey_valid), 64'd0);
  endtask

  initial begin
    reset        = 1'b1;
    start        = 1'b0;
    key_in       = '0;
    decrypt      = 1'b0;
    abort        = 1'b0;
    subkey_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("reset_ready", 64'(ready), 64'd1);
    chk("reset_valid", 64'(subkey_valid), 64'd0);
    chk("reset_round", 64'(round), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_perr", 64'(key_parity_err), 64'd0);
    chk("reset_subkey", 64'(subkey), 64'd0);
    reset = 1'b0;

    // Encrypt order, known vector
    run_key(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    chk("t1_k1", 64'(got_ks[0]), 64'h1B02EFFC7072);
    chk("t1_k16", 64'(got_ks[15]), 64'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++) t1_ks[i] = got_ks[i];

    // Decrypt order is the reverse
    run_key(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, -1, 1'b0);
    chk("t2_k0", 64'(got_ks[0]), 64'hCB3D8B0E17F5);
    for (int i = 0; i < 16; i++)
      chk("t2_reverse", 64'(got_ks[i]), 64'(t1_ks[15 - i]));

    // Back-pressure
    run_key(64'h133457799BBCDFF1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    for (int i = 0; i < 16; i++)
      chk("t3_same_seq", 64'(got_ks[i]), 64'(t1_ks[i]));

    // Abort at round 7, then an all-zero-subkey key
    run_key(64'h133457799BBCDFF1, 1'b0, 1'b0, 1'b0, 7, 1'b0);
    run_key(64'h0101010101010101, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    chk("t4_zero_k", 64'(got_ks[9]), 64'd0);
    chk("t4_perr", 64'(key_parity_err), 64'd0);

    // Parity flag set by an even byte, cleared by the next start
    run_key(64'h0101010101010100, 1'b0, 1'b0, 1'b0, -1, 1'b0);
    run_key(64'h0101010101010101, 1'b1, 1'b0, 1'b0, -1, 1'b0);

    // start together with abort in IDLE is not accepted
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    chk("start_abort_ready", 64'(ready), 64'd1);
    chk("start_abort_valid", 64'(subkey_valid), 64'd0);

    // start poked mid-run is ignored; no extra run follows
    run_key(64'h0E329232EA6D0D73, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("no_extra_run", 64'(subkey_valid), 64'd0);
    end

    // Reset at round 4
    run_key(64'h133457799BBCDFF1, 1'b1, 1'b0, 1'b0, 4, 1'b1);

    // Random keys, directions and back-pressure
    for (int n = 0; n < 5; n++)
      run_key({$urandom, $urandom}, 1'($urandom_range(0, 1)),
              1'b1, 1'b0, -1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
